// File: rtl/inv_key_schedule_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_schedule_pkg
// Brief    : Shared AES-128 key-schedule constants, FSM encoding, Rcon and
//            S-box helper functions.
// Revision : 1.0 - initial release
// ============================================================================
package inv_key_schedule_pkg;

    localparam int c_NK = 4;
    localparam int c_NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_EMIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Round constant for rounds 1..10; anything else yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] v;
        case (n)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // GF(2^8) multiply with the AES polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 maps to 0) followed
    // by the affine transform; avoids carrying a 256-entry table.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inv_key_schedule_step.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_schedule_step
// Brief    : One AES-128 key-schedule step in either direction. Forward
//            produces round r from round r-1; inverse produces round r-1
//            from round r. A single SubWord (four S-boxes) serves both.
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_schedule_step
    import inv_key_schedule_pkg::*;
(
    input  logic [0:127] i_rk,
    input  logic [3:0]   i_round,   // Rcon index applied by this step
    input  logic         i_inv,     // 1 = inverse direction
    output logic [0:127] o_rk
);

    logic [31:0] w_a0, w_a1, w_a2, w_a3;
    logic [31:0] w_p1, w_p2, w_p3;
    logic [31:0] w_sub_in, w_rot, w_sub, w_t;
    logic [31:0] w_f0, w_f1, w_f2, w_f3;

    assign w_a0 = i_rk[0:31];
    assign w_a1 = i_rk[32:63];
    assign w_a2 = i_rk[64:95];
    assign w_a3 = i_rk[96:127];

    // Inverse direction recovers words 1..3 first; p3 then feeds SubWord.
    assign w_p3 = w_a3 ^ w_a2;
    assign w_p2 = w_a2 ^ w_a1;
    assign w_p1 = w_a1 ^ w_a0;

    assign w_sub_in = i_inv ? w_p3 : w_a3;
    assign w_rot    = {w_sub_in[23:0], w_sub_in[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign w_sub[8*i +: 8] = sbox(w_rot[8*i +: 8]);
    end

    assign w_t = w_sub ^ {rcon(i_round), 24'h000000};

    assign w_f0 = w_a0 ^ w_t;
    assign w_f1 = w_f0 ^ w_a1;
    assign w_f2 = w_f1 ^ w_a2;
    assign w_f3 = w_f2 ^ w_a3;

    assign o_rk = i_inv ? {w_a0 ^ w_t, w_p1, w_p2, w_p3}
                        : {w_f0, w_f1, w_f2, w_f3};

endmodule
`default_nettype wire

// File: rtl/inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : inv_key_schedule
// Brief    : AES-128 decryption key schedule. Runs the forward expansion to
//            the last round key, then emits round keys NR down to 0 over a
//            valid/ready handshake by stepping the schedule backwards.
// Revision : 1.0 - initial release
// ============================================================================
module inv_key_schedule
    import inv_key_schedule_pkg::*;
#(
    parameter int NK = c_NK,
    parameter int NR = c_NR
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [0:32*NK-1]  key,
    input  logic              rk_ready,
    output logic              rk_valid,
    output logic [0:32*NK-1]  rk,
    output logic [3:0]        rk_round,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] c_LAST_ROUND = 4'(NR);

    state_t             r_state;
    state_t             w_next_state;
    logic [0:32*NK-1]   r_w;
    logic [3:0]         r_cnt;
    logic [3:0]         w_idx;
    logic               w_inv;
    logic [0:127]       w_step;

    inv_key_schedule_step u_step (
        .i_rk    (r_w),
        .i_round (w_idx),
        .i_inv   (w_inv),
        .o_rk    (w_step)
    );

    // Next-state logic and step direction/Rcon index selection.
    always_comb begin
        w_next_state = r_state;
        w_inv        = 1'b0;
        w_idx        = r_cnt + 4'd1;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_FWD;
            ST_FWD:  if (r_cnt == c_LAST_ROUND) w_next_state = ST_EMIT;
            ST_EMIT: begin
                w_inv = 1'b1;
                w_idx = r_cnt;
                if (rk_ready && (r_cnt == 4'd0)) w_next_state = ST_DONE;
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State, round-key register and round counter; the FWD cycle that sees
    // the last round index only moves to EMIT, giving the 11-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_w     <= '0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_w   <= key;
                        r_cnt <= 4'd0;
                    end
                end
                ST_FWD: begin
                    if (r_cnt != c_LAST_ROUND) begin
                        r_w   <= w_step;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_EMIT: begin
                    if (rk_ready && (r_cnt != 4'd0)) begin
                        r_w   <= w_step;
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rk       = r_w;
    assign rk_round = r_cnt;
    assign rk_valid = (r_state == ST_EMIT);
    assign busy     = (r_state != ST_IDLE);
    assign done     = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: doc/inv_key_schedule.md
INV_KEY_SCHEDULE -- requirements
Module: invKeySchedule

Interface
REQ-001 SHALL have parameter NK, default 4, meaning 32-bit words in the cipher key (AES-128 only; other values unsupported).
REQ-002 SHALL have parameter NR, default 10, meaning number of cipher rounds.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request to begin a schedule run; sampled only in IDLE.
REQ-006 SHALL have port key, input, [0:127]: cipher key, big-endian word order (w0 = key[0:31]); sampled on the edge that accepts start.
REQ-007 SHALL have port rk_ready, input, 1 bit: consumer accepts the presented round key.
REQ-008 SHALL have port rk_valid, output, 1 bit: rk/rk_round hold a valid decryption round key.
REQ-009 SHALL have port rk, output, [0:127]: round key words w[4r..4r+3].
REQ-010 SHALL have port rk_round, output, [3:0]: round index r of rk.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after round 0 handshake.

Function
REQ-013 SHALL implement FSM states IDLE, FWD, EMIT, DONE.
REQ-014 IDLE: on start=1, latch key into round register, set round counter to 0, go to FWD; start=0 stays IDLE.
REQ-015 FWD: each cycle apply the forward step (w'0 = w0^SubWord(RotWord(w3))^Rcon(r+1); w'i = w'(i-1)^wi), increment counter; after the step producing round NR, go to EMIT.
REQ-016 rk_valid SHALL first assert exactly 11 cycles after the edge accepting start, with rk_round=10 and rk = round-10 key.
REQ-017 EMIT: rk_valid=1; while rk_ready=0, rk and rk_round SHALL hold stable.
REQ-018 EMIT handshake (rk_valid & rk_ready) with r>0: next cycle present round r-1 via inverse step: p3=a3^a2, p2=a2^a1, p1=a1^a0, p0=a0^SubWord(RotWord(p3))^Rcon(r).
REQ-019 Throughput: one round key per cycle when rk_ready is held high; 11 keys emitted, rounds 10 down to 0.
REQ-020 Handshake on round 0: rk_valid deasserts next cycle, state DONE, done=1 for exactly one cycle, then IDLE.
REQ-021 start asserted outside IDLE SHALL be ignored; key input ignored outside the accepting edge.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new run needs start in IDLE.
REQ-023 rk_valid SHALL be 0 in IDLE, FWD and DONE.
REQ-024 Rcon(n) SHALL be 01,02,04,08,10,20,40,80,1b,36 in the top byte for n=1..10; all other bytes zero.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, with rk_valid=0, busy=0, done=0, rk=0, rk_round=0, counter=0, regardless of state.
REQ-026 A run interrupted by rst SHALL not resume; the first post-reset output comes only from a new start.
REQ-027 rst and start in the same cycle: rst wins; start is discarded.

Structure
REQ-028 Package aesPkg SHALL hold NK/NR constants, the Rcon table/function, and the FSM state encoding.
REQ-029 Sub-module keyRoundStep SHALL take a 128-bit round key, round index, and direction bit, and return the forward or inverse neighbour.
REQ-030 keyRoundStep SHALL share one subword instance (four sBox) between both directions; no other S-boxes are used.

Verification
REQ-031 Reset, start with key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> after 11 cycles rk_round=10, rk=d014f9a8c9ee2589e13f0cc8b6630ca6; rounds 9..0 on consecutive cycles; round 1 = a0fafe1788542cb123a339392a6c7605; round 0 = key; done pulses once.
REQ-032 Same key, rk_ready toggled pseudo-randomly -> identical 11-key sequence; rk stable whenever rk_valid=1 and rk_ready=0.
REQ-033 start pulsed during FWD and EMIT -> no effect; sequence and cycle count unchanged.
REQ-034 rst asserted mid-EMIT at round 5 -> next cycle IDLE with all outputs 0; new start with key 000102030405060708090a0b0c0d0e0f -> round-10 key 13111d7fe3944a17f307a78b4d2b30c5.
REQ-035 Back-to-back runs: start held high through DONE -> second run begins only from IDLE, one cycle after done; its first rk_valid follows 11 cycles later.
REQ-036 Every emitted key SHALL match the existing keyExpansion output slice for the same cipher key (scoreboard over 100 random keys).
